// File: rtl/fm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fm_seq_pkg
// Description : Shared types, widths and helpers for the fundamental-mode
//               input sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fm_seq_pkg;

  localparam int X_WIDTH    = 2;
  localparam int Z_WIDTH    = 2;
  localparam int MIN_SETTLE = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } state_t;

  // One move toward the target: flip the lowest-index differing bit only,
  // so the async machine never sees a multi-bit input change.
  function automatic logic [X_WIDTH-1:0] next_step(
    input logic [X_WIDTH-1:0] cur,
    input logic [X_WIDTH-1:0] tgt
  );
    logic [X_WIDTH-1:0] diff;
    diff = cur ^ tgt;
    if (diff[0]) begin
      next_step = cur ^ 2'b01;
    end else if (diff[1]) begin
      next_step = cur ^ 2'b10;
    end else begin
      next_step = cur;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Width/depth parameterised flop synchroniser, async low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int WIDTH  = 2,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < 1) begin : g_bad_stages
    $error("sync_ff: STAGES must be at least 1");
  end

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  // Shift chain: stage 0 captures the raw input, each later stage the one before.
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Synchroniser flops, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/fm_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fm_input_sequencer
// Description : Walks the input of a fundamental-mode async machine toward a
//               requested vector one bit at a time, settling after each
//               change, then returns the synchronised output sample.
// Revision    : 1.0 - initial release
// ============================================================================
module fm_input_sequencer
  import fm_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [X_WIDTH-1:0] req_x,
  output logic [X_WIDTH-1:0] x_drv,
  input  logic [Z_WIDTH-1:0] z_in,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [Z_WIDTH-1:0] rsp_z,
  output logic [1:0]         rsp_steps,
  output logic               busy
);

  // The settle window must outlast the synchroniser latency.
  if (SETTLE_CYCLES < MIN_SETTLE) begin : g_bad_settle
    $error("fm_input_sequencer: SETTLE_CYCLES must be >= %0d", MIN_SETTLE);
  end

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  state_t             state_q,     state_d;
  logic [X_WIDTH-1:0] x_drv_q,     x_drv_d;
  logic [X_WIDTH-1:0] tgt_q,       tgt_d;
  logic [1:0]         steps_q,     steps_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [Z_WIDTH-1:0] rsp_z_q,     rsp_z_d;
  logic [1:0]         rsp_steps_q, rsp_steps_d;
  logic [Z_WIDTH-1:0] z_sync;

  sync_ff #(
    .WIDTH  (Z_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_z_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (z_in),
    .q     (z_sync)
  );

  // Next-state and datapath updates; every register holds unless a state acts.
  always_comb begin
    state_d     = state_q;
    x_drv_d     = x_drv_q;
    tgt_d       = tgt_q;
    steps_d     = steps_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_z_d     = rsp_z_q;
    rsp_steps_d = rsp_steps_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          tgt_d   = req_x;
          steps_d = 2'd0;
          state_d = STEP;
        end
      end
      STEP: begin
        if (x_drv_q == tgt_q) begin
          rsp_z_d     = z_sync;
          rsp_steps_d = steps_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          x_drv_d = next_step(x_drv_q, tgt_q);
          steps_d = steps_q + 2'd1;
          cnt_d   = CNT_W'(SETTLE_CYCLES);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = STEP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_drv_q     <= '0;
      tgt_q       <= '0;
      steps_q     <= 2'd0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_steps_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      x_drv_q     <= x_drv_d;
      tgt_q       <= tgt_d;
      steps_q     <= steps_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q     <= rsp_z_d;
      rsp_steps_q <= rsp_steps_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign x_drv     = x_drv_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_steps = rsp_steps_q;

endmodule
`default_nettype wire

// File: tb/tb_fm_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fm_input_sequencer
// Description : Self-checking bench for fm_input_sequencer with a schedule
//               based reference model and a small async machine model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_input_sequencer;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_x = 2'b00;
  logic [1:0] x_drv;
  logic [1:0] z_in;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [1:0] rsp_z;
  logic [1:0] rsp_steps;
  logic       busy;

  logic [1:0] z_drv = 2'b00;
  logic       use_machine = 1'b0;
  logic [1:0] mach_y = 2'b00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fm_input_sequencer #(
    .SETTLE_CYCLES (S),
    .SYNC_STAGES   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .x_drv     (x_drv),
    .z_in      (z_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_steps (rsp_steps),
    .busy      (busy)
  );

  // Two-state-variable async machine: y0 is a Muller C-element on x,
  // y1 is set by x=10 and held while x1 stays high. Output Z = {y1, y0}.
  always @(x_drv) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      mach_y[0] = (x_drv[0] & x_drv[1]) | (mach_y[0] & (x_drv[0] | x_drv[1]));
      mach_y[1] = (x_drv[1] & ~x_drv[0]) | (mach_y[1] & x_drv[1]);
    end
  end

  assign z_in = use_machine ? mach_y : z_drv;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // On accept, the whole transaction is planned: change times and the
  // response time follow from the number of differing bits.
  bit         m_busy, m_valid;
  logic [1:0] m_x, m_tgt, m_z, m_steps, zq1;
  int         m_n, m_t1, m_t2, m_tr;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_valid = 0; m_x = 2'b00; m_z = 2'b00; m_steps = 2'b00;
        zq1 = 2'b00;
      end else begin
        cyc++;
        if (!m_busy) begin
          if (req_valid) begin
            m_busy = 1;
            m_tgt  = req_x;
            m_n    = int'(m_x[0] != req_x[0]) + int'(m_x[1] != req_x[1]);
            m_t1   = cyc + 1;
            m_t2   = cyc + 2 + S;
            m_tr   = (m_n == 0) ? cyc + 1 : (m_n == 1) ? cyc + 2 + S : cyc + 3 + 2 * S;
          end
        end else if (m_valid) begin
          if (rsp_ready) begin
            m_valid = 0;
            m_busy  = 0;
          end
        end else begin
          if ((cyc == m_t1 || cyc == m_t2) && m_x != m_tgt) begin
            if (m_x[0] != m_tgt[0]) m_x[0] = m_tgt[0];
            else                    m_x[1] = m_tgt[1];
          end
          if (cyc == m_tr) begin
            m_valid = 1;
            m_z     = zq1;
            m_steps = 2'(m_n);
          end
        end
        zq1 = z_in;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("x_drv", x_drv, m_x);
        chk("rsp_valid", rsp_valid, m_valid);
        chk("req_ready", req_ready, !m_busy);
        chk("busy", busy, m_busy);
        if (m_valid || !rst_n) begin
          chk("rsp_z", rsp_z, m_z);
          chk("rsp_steps", rsp_steps, m_steps);
        end
      end
    end
  end

  // Issue one request, measure latency to rsp_valid and check the literal
  // expectations; optionally complete the response handshake.
  task automatic do_req(input logic [1:0] x, input int lat, input logic [1:0] ez,
                        input int esteps, input bit hold);
    int  e;
    bit  found;
    @(negedge clk);
    req_valid = 1'b1;
    req_x     = x;
    @(posedge clk);
    #1 e = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      if (rsp_valid) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rsp_seen", found, 1);
    if (found) begin
      chk("latency", cyc - e, lat);
      chk("lit_rsp_z", rsp_z, ez);
      chk("lit_rsp_steps", rsp_steps, esteps);
      chk("lit_x_drv", x_drv, x);
    end
    if (!hold) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("ready_after_resp", req_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // 1: asynchronous reset mid-clock
    #2 rst_n = 1'b0;
    #1;
    chk("rst_x_drv", x_drv, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_x_drv", x_drv, 0);
    chk("idle_req_ready", req_ready, 1);

    // 2: 00 -> 01, one change
    z_drv = 2'b10;
    do_req(2'b01, S + 2, 2'b10, 1, 0);
    // 3: 01 -> 10 through 00, two changes
    z_drv = 2'b11;
    do_req(2'b10, 2 * S + 3, 2'b11, 2, 0);
    // 4: already at target
    do_req(2'b10, 1, 2'b11, 0, 0);

    // 5: response back-pressure; request inputs ignored while busy
    do_req(2'b00, S + 2, 2'b11, 1, 1);
    for (int k = 0; k < 10; k++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_x     = 2'($urandom_range(0, 3));
      z_drv     = 2'($urandom_range(0, 3));
      @(negedge clk);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_rsp_z", rsp_z, 2'b11);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("release_req_ready", req_ready, 1);

    // 6: reset during SETTLE of a 00 -> 11 request
    @(negedge clk);
    req_valid = 1'b1;
    req_x     = 2'b11;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_x_drv", x_drv, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("no_rsp_after_abort", seen, 0);

    // async machine in the loop: settled Z per target
    use_machine = 1'b1;
    repeat (2) @(negedge clk);
    do_req(2'b00, 1,     2'b00, 0, 0);
    do_req(2'b01, S + 2, 2'b00, 1, 0);
    do_req(2'b11, S + 2, 2'b01, 1, 0);
    do_req(2'b10, S + 2, 2'b11, 1, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
